// File: rtl/qam16_pkg.sv
// qam16_pkg: shared QAM16 widths, sample types, pulse-shaping coefficients and output scaling.
// Optional QAM16_PS_ROUND_EN selects round-half-up instead of truncation in scale().
package qam16_pkg;
  localparam int IN_W = 4;
  localparam int COEF_W = 8;
  localparam int NTAPS = 16;
  localparam int ACC_W = 16;
  localparam int SHIFT = 4;
  localparam int OUT_W = ACC_W - SHIFT;
  localparam int PROD_W = IN_W + COEF_W;
  typedef logic signed [IN_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [OUT_W-1:0] out_t;
  localparam coef_t COEF [0:NTAPS-1] = '{
    -8'sd1, -8'sd3, -8'sd4, 8'sd0, 8'sd12, 8'sd30, 8'sd50, 8'sd64,
    8'sd64, 8'sd50, 8'sd30, 8'sd12, 8'sd0, -8'sd4, -8'sd3, -8'sd1
  };
  // The accumulator has headroom for the rounding offset, so no saturation is needed.
  function automatic out_t scale(acc_t acc);
`ifdef QAM16_PS_ROUND_EN
    acc_t r = acc + acc_t'(2 ** (SHIFT - 1));
`else
    acc_t r = acc;
`endif
    return out_t'(r >>> SHIFT);
  endfunction
endpackage

// File: rtl/qam16_fir_branch.sv
// qam16_fir_branch: one rail of the 16-tap pulse shaper: delay line, product regs, adder, output reg.
// Output scaling follows QAM16_PS_ROUND_EN via qam16_pkg::scale.
module qam16_fir_branch
  import qam16_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    out_valid
);
  sample_t tap_q [NTAPS];
  sample_t tap_d [NTAPS];
  prod_t prod_q [NTAPS];
  prod_t prod_d [NTAPS];
  acc_t acc_q, acc_d;
  out_t dout_q, dout_d;
  logic [2:0] vld_q, vld_d;
  logic out_valid_q, out_valid_d;
  always_comb begin
    tap_d[0] = in_valid ? din : tap_q[0];
    for (int k = 1; k < NTAPS; k++) tap_d[k] = in_valid ? tap_q[k-1] : tap_q[k];
    for (int k = 0; k < NTAPS; k++) prod_d[k] = prod_t'(tap_q[k]) * prod_t'(COEF[k]);
    acc_d = '0;
    for (int k = 0; k < NTAPS; k++) acc_d = acc_d + acc_t'(prod_q[k]);
    vld_d = {vld_q[1:0], in_valid};
    out_valid_d = vld_q[2];
    dout_d = vld_q[2] ? scale(acc_q) : dout_q;
  end
  // Data stages run every cycle; only the valid chain decides when the output register loads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap_q <= '{default: '0};
      prod_q <= '{default: '0};
      acc_q <= '0;
      dout_q <= '0;
      vld_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      tap_q <= tap_d;
      prod_q <= prod_d;
      acc_q <= acc_d;
      dout_q <= dout_d;
      vld_q <= vld_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign dout = dout_q;
  assign out_valid = out_valid_q;
endmodule

// File: rtl/qam16_pulse_shaper.sv
// qam16_pulse_shaper: I/Q raised-cosine pulse shaper downstream of the QAM16 upsampler.
// Define QAM16_PS_ROUND_EN for round-half-up output scaling; default truncates.
module qam16_pulse_shaper
  import qam16_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  iup,
  input  logic signed [IN_W-1:0]  qup,
  output logic signed [OUT_W-1:0] i_shaped,
  output logic signed [OUT_W-1:0] q_shaped,
  output logic                    out_valid
);
  logic i_vld, q_vld;
  qam16_fir_branch u_i (
    .clk(clk), .reset(reset), .in_valid(in_valid), .din(iup), .dout(i_shaped), .out_valid(i_vld)
  );
  qam16_fir_branch u_q (
    .clk(clk), .reset(reset), .in_valid(in_valid), .din(qup), .dout(q_shaped), .out_valid(q_vld)
  );
  // Both rails share in_valid and reset, so their valid chains are identical.
  assign out_valid = i_vld & q_vld;
endmodule

// File: tb/tb_qam16_pulse_shaper.sv
// tb_qam16_pulse_shaper: randomized and directed checks of the pulse shaper against a behavioural model.
module tb_qam16_pulse_shaper;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic signed [3:0] iup = '0, qup = '0;
  logic signed [11:0] i_shaped, q_shaped;
  logic out_valid;
  int checks = 0, errors = 0;
  int vi[$], vq[$];
  int C[16] = '{-1, -3, -4, 0, 12, 30, 50, 64, 64, 50, 30, 12, 0, -4, -3, -1};
`ifdef QAM16_PS_ROUND_EN
  int IMP_P[16] = '{0, -1, -1, 0, 2, 6, 9, 12, 12, 9, 6, 2, 0, -1, -1, 0};
  int IMP_N[16] = '{0, 1, 1, 0, -2, -6, -9, -12, -12, -9, -6, -2, 0, 1, 1, 0};
  int DC = 19;
  int FIRST = 0;
`else
  int IMP_P[16] = '{-1, -1, -1, 0, 2, 5, 9, 12, 12, 9, 5, 2, 0, -1, -1, -1};
  int IMP_N[16] = '{0, 0, 0, 0, -3, -6, -10, -12, -12, -10, -6, -3, 0, 0, 0, 0};
  int DC = 18;
  int FIRST = -1;
`endif

  qam16_pulse_shaper dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .iup(iup), .qup(qup),
    .i_shaped(i_shaped), .q_shaped(q_shaped), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, integer act, integer exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int shape(int acc);
`ifdef QAM16_PS_ROUND_EN
    return (acc + 8) >>> 4;
`else
    return acc >>> 4;
`endif
  endfunction

  // Model: sample history since reset, filtered directly, result released 3 edges later.
  int hi[16], hq[16];
  bit pv[3];
  int pi_[3], pq[3];
  bit exp_v;
  int exp_i, exp_q;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi = '{default: 0};
      hq = '{default: 0};
      pv = '{default: 0};
      pi_ = '{default: 0};
      pq = '{default: 0};
      exp_v = 0;
      exp_i = 0;
      exp_q = 0;
    end else begin
      int si, sq;
      exp_v = pv[2];
      if (pv[2]) begin
        exp_i = pi_[2];
        exp_q = pq[2];
      end
      pv[2] = pv[1]; pi_[2] = pi_[1]; pq[2] = pq[1];
      pv[1] = pv[0]; pi_[1] = pi_[0]; pq[1] = pq[0];
      pv[0] = in_valid;
      if (in_valid) begin
        for (int k = 15; k > 0; k--) begin
          hi[k] = hi[k-1];
          hq[k] = hq[k-1];
        end
        hi[0] = iup;
        hq[0] = qup;
        si = 0;
        sq = 0;
        for (int k = 0; k < 16; k++) begin
          si += C[k] * hi[k];
          sq += C[k] * hq[k];
        end
        pi_[0] = shape(si);
        pq[0] = shape(sq);
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", out_valid, exp_v);
    chk("i_shaped", i_shaped, exp_i);
    chk("q_shaped", q_shaped, exp_q);
    if (out_valid) begin
      vi.push_back(i_shaped);
      vq.push_back(q_shaped);
    end
  end

  task automatic step(bit v, int i, int q);
    @(posedge clk);
    #1;
    in_valid = v;
    iup = i[3:0];
    qup = q[3:0];
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 0;
    in_valid = 0;
    iup = 0;
    qup = 0;
    @(posedge clk);
    #1;
    reset = 1;
    vi.delete();
    vq.delete();
  endtask

  task automatic flush();
    for (int k = 0; k < 5; k++) step(0, 0, 0);
  endtask

  task automatic check_vec(string name, int got[$], int v[16]);
    chk({name, "_count"}, got.size() >= 16, 1);
    for (int k = 0; k < 16; k++) chk(name, k < got.size() ? got[k] : 9999, v[k]);
  endtask

  initial begin
    int zero16[16] = '{default: 0};
    #1;
    chk("reset_valid", out_valid, 0);
    chk("reset_i", i_shaped, 0);
    chk("reset_q", q_shaped, 0);
    do_reset();
    // Positive impulse on I, Q held at 0, continuous valid; first result exactly 3 edges after capture.
    step(1, 3, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0);
      chk("latency_idle", out_valid, 0);
    end
    step(1, 0, 0);
    chk("latency_valid", out_valid, 1);
    chk("latency_first", i_shaped, IMP_P[0]);
    for (int k = 0; k < 20; k++) step(1, 0, 0);
    flush();
    check_vec("impulse_i", vi, IMP_P);
    chk("impulse_tail", vi.size() > 20 ? vi[20] : 9999, 0);
    check_vec("indep_q", vq, zero16);
    // Same impulse with in_valid toggling.
    do_reset();
    step(1, 3, 0);
    for (int j = 0; j < 40; j++) step(j % 2 == 1, 0, 0);
    flush();
    check_vec("gapped_i", vi, IMP_P);
    // Negative impulse on both rails.
    do_reset();
    step(1, -3, -3);
    for (int k = 0; k < 20; k++) step(1, 0, 0);
    flush();
    check_vec("neg_i", vi, IMP_N);
    check_vec("neg_q", vq, IMP_N);
    // DC input.
    do_reset();
    for (int k = 0; k < 30; k++) step(1, 1, 1);
    flush();
    chk("dc_i", vi.size() > 0 ? vi[vi.size()-1] : 9999, DC);
    chk("dc_q", vq.size() > 0 ? vq[vq.size()-1] : 9999, DC);
    // Random stream, then reset mid-stream with in_valid high.
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 15), $urandom_range(0, 15));
    for (int k = 0; k < 10; k++) step(1, 7, -8);
    @(posedge clk);
    #1;
    reset = 0;
    in_valid = 1;
    #1;
    chk("midreset_valid", out_valid, 0);
    chk("midreset_i", i_shaped, 0);
    chk("midreset_q", q_shaped, 0);
    @(posedge clk);
    #1;
    chk("midreset_hold", out_valid, 0);
    reset = 1;
    in_valid = 0;
    vi.delete();
    vq.delete();
    step(1, 3, 3);
    flush();
    chk("post_reset_i", vi.size() > 0 ? vi[0] : 9999, FIRST);
    chk("post_reset_q", vq.size() > 0 ? vq[0] : 9999, FIRST);
    for (int k = 0; k < 200; k++)
      step($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15));
    flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
